instr_issue_queue: RTL and testbench

//  In-order instruction queue between fetch and the scoreboard/issue stage.

---
 rtl/instr_issue_queue.sv | 161 ++++++++++++++++
 tb/tb_instr_issue_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_queue.sv
// rtl/instr_issue_queue.sv - In-order fetch-to-issue instruction queue with field pre-decode
//
// Buffers {pc, instr} pairs from fetch and presents the head entry to the
// scoreboard. The head is held while stall=1. kill=1 empties the queue at the
// next edge.
//
// Ports:
//   clk, nrst                      clock, asynchronous active-low reset
//   push_valid/push_ready          fetch handshake (push_ready = !full)
//   push_pc, push_instr            entry being pushed
//   stall, kill                    scoreboard hold / flush
//   out_valid, out_pc, out_instr   head entry (zero while empty)
//   out_opcode, out_rs1/rs2/rd     head fields; fields the opcode does not use read 0
//   count                          number of occupied entries

module instr_issue_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [XLEN-1:0]          push_pc,
    input  logic [31:0]              push_instr,
    input  logic                     stall,
    input  logic                     kill,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_pc,
    output logic [31:0]              out_instr,
    output logic [6:0]               out_opcode,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [4:0]               out_rd,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] DEPTH_PW = PW'(DEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] pc_mem_d    [DEPTH];
    logic [31:0]     instr_mem_q [DEPTH];
    logic [31:0]     instr_mem_d [DEPTH];

    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;
    logic [PW-1:0]   occupancy;
    logic            full;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] head_pc;
    logic [31:0]     head_instr;
    logic            use_rs1;
    logic            use_rs2;
    logic            use_rd;

    assign wr_idx     = wr_ptr_q[AW-1:0];
    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign occupancy  = wr_ptr_q - rd_ptr_q;
    assign full       = (occupancy == DEPTH_PW);
    assign count      = occupancy;
    assign out_valid  = (occupancy != '0);

    // push_ready depends only on registered state, never on stall/kill.
    assign push_ready = !full;
    assign push       = push_valid && push_ready && !kill;
    assign pop        = out_valid && !stall && !kill;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        if (kill) begin
            // Flush by collapsing the write pointer onto the read pointer.
            wr_ptr_d = rd_ptr_q;
        end else begin
            if (push) begin
                pc_mem_d[wr_idx]    = push_pc;
                instr_mem_d[wr_idx] = push_instr;
                wr_ptr_d            = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end

    // Head data is gated with out_valid so an empty queue drives all zeros.
    assign head_pc    = out_valid ? pc_mem_q[rd_idx]    : '0;
    assign head_instr = out_valid ? instr_mem_q[rd_idx] : '0;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (head_instr[6:0])
            OP_LUI, OP_AUIPC, OP_JAL: begin
                use_rd = 1'b1;
            end
            OP_OPIMM, OP_LOAD, OP_JALR: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
            end
            default: begin
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
                use_rd  = 1'b0;
            end
        endcase
    end

    assign out_pc     = head_pc;
    assign out_instr  = head_instr;
    assign out_opcode = head_instr[6:0];
    assign out_rs1    = use_rs1 ? head_instr[19:15] : 5'd0;
    assign out_rs2    = use_rs2 ? head_instr[24:20] : 5'd0;
    assign out_rd     = use_rd  ? head_instr[11:7]  : 5'd0;

endmodule

// File: tb/tb_instr_issue_queue.sv
// tb/tb_instr_issue_queue.sv - Self-checking bench for instr_issue_queue

module tb_instr_issue_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            nrst;
    logic            push_valid;
    logic            push_ready;
    logic [XLEN-1:0] push_pc;
    logic [31:0]     push_instr;
    logic            stall;
    logic            kill;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [2:0]      count;

    instr_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_pc    (push_pc),
        .push_instr (push_instr),
        .stall      (stall),
        .kill       (kill),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .out_opcode (out_opcode),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_rd     (out_rd),
        .count      (count)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    entry_t mq[$];

    // Which register fields an RV32I opcode actually reads/writes: {rs1,rs2,rd}.
    function automatic logic [2:0] field_use(input logic [6:0] op);
        case (op)
            7'h37, 7'h17, 7'h6F: return 3'b001;
            7'h13, 7'h03, 7'h67: return 3'b101;
            7'h63, 7'h23:        return 3'b110;
            7'h33:               return 3'b111;
            default:             return 3'b000;
        endcase
    endfunction

    task automatic model_step(input logic pv, input logic [XLEN-1:0] pc,
                              input logic [31:0] ins, input logic st, input logic kl);
        bit do_push;
        bit do_pop;
        entry_t e;
        do_push = pv && (mq.size() < DEPTH) && !kl;
        do_pop  = (mq.size() > 0) && !st && !kl;
        if (kl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.pc = pc;
                e.instr = ins;
                mq.push_back(e);
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [2:0] u;
        logic [31:0] hi;
        check({tag, ".count"}, 64'(count), 64'(mq.size()));
        check({tag, ".valid"}, 64'(out_valid), 64'(mq.size() != 0));
        check({tag, ".ready"}, 64'(push_ready), 64'(mq.size() < DEPTH));
        hi = (mq.size() != 0) ? mq[0].instr : 32'h0;
        u  = field_use(hi[6:0]);
        check({tag, ".pc"}, 64'(out_pc), 64'((mq.size() != 0) ? mq[0].pc : '0));
        check({tag, ".instr"}, 64'(out_instr), 64'(hi));
        check({tag, ".opcode"}, 64'(out_opcode), 64'(hi[6:0]));
        check({tag, ".rs1"}, 64'(out_rs1), 64'(u[2] ? hi[19:15] : 5'd0));
        check({tag, ".rs2"}, 64'(out_rs2), 64'(u[1] ? hi[24:20] : 5'd0));
        check({tag, ".rd"},  64'(out_rd),  64'(u[0] ? hi[11:7]  : 5'd0));
    endtask

    // Apply inputs, clock once, advance model, sample #1 after the edge.
    task automatic cycle(input logic pv, input logic [XLEN-1:0] pc, input logic [31:0] ins,
                         input logic st, input logic kl, input string tag);
        push_valid = pv;
        push_pc    = pc;
        push_instr = ins;
        stall      = st;
        kill       = kl;
        @(posedge clk);
        model_step(pv, pc, ins, st, kl);
        #1;
        check_model(tag);
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        st;
        logic        kl;
        logic        e_valid;
        logic        e_ready;
        logic [2:0]  e_count;
        logic [31:0] e_pc;
        logic [4:0]  e_rs1;
        logic [4:0]  e_rs2;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t vecs[9];

    logic [6:0] rnd_ops[10];

    initial begin
        vecs[0] = '{1, 32'h100, 32'h00500093, 0, 0, 1, 1, 3'd1, 32'h100, 5'd0, 5'd0, 5'd1};
        vecs[1] = '{1, 32'h104, 32'h0020A023, 1, 0, 1, 1, 3'd2, 32'h100, 5'd0, 5'd0, 5'd1};
        vecs[2] = '{1, 32'h108, 32'h000012B7, 1, 0, 1, 1, 3'd3, 32'h100, 5'd0, 5'd0, 5'd1};
        vecs[3] = '{1, 32'h10C, 32'h002081B3, 1, 0, 1, 0, 3'd4, 32'h100, 5'd0, 5'd0, 5'd1};
        vecs[4] = '{1, 32'h110, 32'h00000013, 1, 0, 1, 0, 3'd4, 32'h100, 5'd0, 5'd0, 5'd1};
        vecs[5] = '{0, 32'h0,   32'h0,        0, 0, 1, 1, 3'd3, 32'h104, 5'd1, 5'd2, 5'd0};
        vecs[6] = '{0, 32'h0,   32'h0,        0, 0, 1, 1, 3'd2, 32'h108, 5'd0, 5'd0, 5'd5};
        vecs[7] = '{0, 32'h0,   32'h0,        0, 0, 1, 1, 3'd1, 32'h10C, 5'd1, 5'd2, 5'd3};
        vecs[8] = '{0, 32'h0,   32'h0,        0, 0, 0, 1, 3'd0, 32'h0,   5'd0, 5'd0, 5'd0};

        rnd_ops[0] = 7'h37; rnd_ops[1] = 7'h17; rnd_ops[2] = 7'h6F; rnd_ops[3] = 7'h13;
        rnd_ops[4] = 7'h03; rnd_ops[5] = 7'h67; rnd_ops[6] = 7'h63; rnd_ops[7] = 7'h23;
        rnd_ops[8] = 7'h33; rnd_ops[9] = 7'h73;

        nrst = 1'b0;
        push_valid = 1'b0;
        push_pc = '0;
        push_instr = '0;
        stall = 1'b0;
        kill = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.valid", 64'(out_valid), 64'd0);
        check("reset.count", 64'(count), 64'd0);
        check("reset.ready", 64'(push_ready), 64'd1);
        check("reset.pc", 64'(out_pc), 64'd0);
        check("reset.instr", 64'(out_instr), 64'd0);
        nrst = 1'b1;
        #2;

        // Table vectors: addi push, stalled fill, ignored 5th push, ordered drain.
        for (int i = 0; i < 9; i++) begin
            push_valid = vecs[i].pv;
            push_pc    = vecs[i].pc;
            push_instr = vecs[i].instr;
            stall      = vecs[i].st;
            kill       = vecs[i].kl;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.valid", i), 64'(out_valid), 64'(vecs[i].e_valid));
            check($sformatf("vec%0d.ready", i), 64'(push_ready), 64'(vecs[i].e_ready));
            check($sformatf("vec%0d.count", i), 64'(count), 64'(vecs[i].e_count));
            check($sformatf("vec%0d.pc", i), 64'(out_pc), 64'(vecs[i].e_pc));
            check($sformatf("vec%0d.rs1", i), 64'(out_rs1), 64'(vecs[i].e_rs1));
            check($sformatf("vec%0d.rs2", i), 64'(out_rs2), 64'(vecs[i].e_rs2));
            check($sformatf("vec%0d.rd", i), 64'(out_rd), 64'(vecs[i].e_rd));
        end
        mq.delete();

        // Full queue, stall released while fetch keeps pushing: in-order, wrapping.
        for (int i = 0; i < 4; i++)
            cycle(1, 32'h200 + 32'(i * 4), 32'h00000013 | (32'(i + 1) << 7), 1, 0, "fill");
        for (int i = 0; i < 4; i++)
            cycle(1, 32'h300 + 32'(i * 4), 32'h002081B3 | (32'(i) << 7), 0, 0, "stream");
        for (int i = 0; i < 5; i++)
            cycle(0, 32'h0, 32'h0, 0, 0, "drain");

        // Kill with stall and push in the same cycle at count=3.
        for (int i = 0; i < 3; i++)
            cycle(1, 32'h400 + 32'(i * 4), 32'h0020A023, 1, 0, "kfill");
        check("kill.pre_count", 64'(count), 64'd3);
        cycle(1, 32'h4F0, 32'h000012B7, 1, 1, "kill");
        check("kill.count", 64'(count), 64'd0);
        check("kill.valid", 64'(out_valid), 64'd0);
        cycle(1, 32'h500, 32'h000012B7, 1, 0, "postkill");
        check("postkill.pc", 64'(out_pc), 64'h500);
        cycle(0, 32'h0, 32'h0, 0, 0, "postkill_pop");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            ins = $urandom();
            ins[6:0] = rnd_ops[$urandom_range(0, 9)];
            cycle(($urandom_range(0, 9) < 7), $urandom(), ins,
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), "rand");
        end

        // Async reset mid-operation with two entries queued.
        cycle(0, 32'h0, 32'h0, 0, 1, "pre_rst");
        cycle(1, 32'h600, 32'h00500093, 1, 0, "rfill0");
        cycle(1, 32'h604, 32'h00500093, 1, 0, "rfill1");
        check("arst.pre_count", 64'(count), 64'd2);
        #2;
        nrst = 1'b0;
        #1;
        check("arst.valid", 64'(out_valid), 64'd0);
        check("arst.count", 64'(count), 64'd0);
        check("arst.ready", 64'(push_ready), 64'd1);
        check("arst.pc", 64'(out_pc), 64'd0);
        mq.delete();
        push_valid = 1'b0;
        @(posedge clk);
        #2;
        nrst = 1'b1;
        cycle(1, 32'h700, 32'h000012B7, 0, 0, "after_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
